// File: rtl/shift_seq_unit.sv
// Purpose: multi-cycle shift/rotate unit (SLL, SRL, SRA, ROL) that moves up to STEP bit positions per cycle.
// Latency: ceil(amt/STEP)+1 edges from the accept edge to out_valid. An amount of 0 gives out_valid after 1 edge.
// Backpressure: only one operation is in flight; in_ready is low from accept until the out_ready handshake,
//   and the result is held stable while out_ready is low.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               request handshake (in_data operand, in_amt amount, in_mode op)
//   out_valid/out_ready             result handshake (out_data, out_carry, out_zero)
module shift_seq_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // STEP <= WIDTH/2, so it always fits in the SHW-bit amount width.
  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

  state_t           state, stateNext;
  logic [WIDTH-1:0] dataReg, dataStep;
  logic [SHW-1:0]   countReg, stepK, countRem, leftIdx, rightIdx;
  logic [1:0]       modeReg;
  logic             carryReg, carryStep;

  // One shift step of k = min(STEP, count) positions.
  always_comb begin
    stepK     = (countReg < STEP_AMT) ? countReg : STEP_AMT;
    countRem  = countReg - stepK;
    // Modulo-WIDTH arithmetic: 0 - k == WIDTH - k, the last bit to leave on the left.
    leftIdx   = '0 - stepK;
    rightIdx  = stepK - SHW'(1);
    dataStep  = dataReg;
    carryStep = 1'b0;
    case (modeReg)
      MODE_SLL: begin
        dataStep  = dataReg << stepK;
        carryStep = dataReg[leftIdx];
      end
      MODE_SRL: begin
        dataStep  = dataReg >> stepK;
        carryStep = dataReg[rightIdx];
      end
      MODE_SRA: begin
        dataStep  = $signed(dataReg) >>> stepK;
        carryStep = dataReg[rightIdx];
      end
      default: begin
        // ROL: in SHIFT k >= 1, so leftIdx is in WIDTH/2..WIDTH-1 and the wrap term is well defined.
        dataStep  = (dataReg << stepK) | (dataReg >> leftIdx);
        carryStep = dataReg[leftIdx];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (in_valid) stateNext = (in_amt == '0) ? DONE : SHIFT;
      SHIFT:   if (countRem == '0) stateNext = DONE;
      DONE:    if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg  <= '0;
      countReg <= '0;
      modeReg  <= MODE_SLL;
      carryReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dataReg  <= in_data;
            countReg <= in_amt;
            modeReg  <= in_mode;
            carryReg <= 1'b0;
          end
        end
        SHIFT: begin
          dataReg  <= dataStep;
          countReg <= countRem;
          carryReg <= carryStep;
        end
        default: ;
      endcase
    end
  end

  // The handshake outputs are decoded from state only, so neither depends combinationally on an input.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = dataReg;
  assign out_carry = carryReg;
  assign out_zero  = (dataReg == '0);

endmodule
